// File: rtl/subservient_loader.sv
// Byte-stream program loader: packs bytes into words and writes them over a debug Wishbone port.
// Define SUBSERVIENT_LOADER_READBACK_EN to read back and verify each word after writing it.
module subservient_loader #(
    parameter int memsize = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_debug_mode,
    output logic        o_cpu_rst,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack,
    output logic        o_done,
    output logic        o_err
);

    localparam int AW = $clog2(memsize / 4);

`ifdef SUBSERVIENT_LOADER_READBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_RELEASE, S_CHECK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_RELEASE} state_t;
`endif

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [1:0]    lane_q;
    logic          last_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          ready_q, dbg_q, cpurst_q, stb_q, done_q, err_q;
    logic          ack_hit;
    logic          adv;

    assign addr_d  = addr_q + 1'b1;
    assign ack_hit = stb_q & i_wb_dbg_ack;

`ifdef SUBSERVIENT_LOADER_READBACK_EN
    logic        we_q;
    logic [31:0] rb_mask;
    logic        rb_mismatch;

    assign rb_mask     = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
    assign rb_mismatch = |((i_wb_dbg_rdt ^ dat_q) & rb_mask);
    assign adv         = (state_q == S_CHECK) & ack_hit;
    assign o_wb_dbg_we = we_q;
`else
    logic unused_rdt;

    assign unused_rdt  = ^i_wb_dbg_rdt;
    assign adv         = (state_q == S_WRITE) & ack_hit;
    assign o_wb_dbg_we = stb_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            lane_q   <= 2'd0;
            last_q   <= 1'b0;
            dat_q    <= 32'd0;
            sel_q    <= 4'd0;
            ready_q  <= 1'b0;
            dbg_q    <= 1'b0;
            cpurst_q <= 1'b0;
            stb_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
            we_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q  <= S_COLLECT;
                        addr_q   <= '0;
                        lane_q   <= 2'd0;
                        last_q   <= 1'b0;
                        dat_q    <= 32'd0;
                        sel_q    <= 4'd0;
                        err_q    <= 1'b0;
                        ready_q  <= 1'b1;
                        dbg_q    <= 1'b1;
                        cpurst_q <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (i_valid && ready_q) begin
                        dat_q[{lane_q, 3'b000} +: 8] <= i_data;
                        sel_q[lane_q] <= 1'b1;
                        lane_q        <= lane_q + 2'd1;
                        last_q        <= i_last;
                        if (lane_q == 2'd3 || i_last) begin
                            state_q <= S_WRITE;
                            ready_q <= 1'b0;
                            stb_q   <= 1'b1;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
                            we_q    <= 1'b1;
`endif
                        end
                    end
                end
                S_WRITE: begin
                    if (ack_hit) begin
                        stb_q   <= 1'b0;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
                        we_q    <= 1'b0;
                        state_q <= S_CHECK;
`endif
                    end
                end
`ifdef SUBSERVIENT_LOADER_READBACK_EN
                S_CHECK: begin
                    // One idle cycle after the write ack, then the read strobe.
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                    end else if (ack_hit) begin
                        stb_q <= 1'b0;
                        if (rb_mismatch)
                            err_q <= 1'b1;
                    end
                end
`endif
                S_RELEASE: begin
                    cpurst_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Word completed: advance address and pick the next phase.
            if (adv) begin
                addr_q <= addr_d;
                if (&addr_q)
                    err_q <= 1'b1;
                lane_q <= 2'd0;
                dat_q  <= 32'd0;
                sel_q  <= 4'd0;
                if (last_q) begin
                    state_q <= S_RELEASE;
                    dbg_q   <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_COLLECT;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    assign o_ready      = ready_q;
    assign o_debug_mode = dbg_q;
    assign o_cpu_rst    = cpurst_q;
    assign o_wb_dbg_adr = {{(30 - AW){1'b0}}, addr_q, 2'b00};
    assign o_wb_dbg_dat = dat_q;
    assign o_wb_dbg_sel = sel_q;
    assign o_wb_dbg_stb = stb_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_subservient_loader.sv
// Scoreboard bench for subservient_loader (memsize=16): expected writes queued by stimulus, checked by a bus monitor.
module tb_subservient_loader;

    logic        clk = 1'b0;
    logic        rst, start, valid, last;
    logic [7:0]  data;
    logic        ready, dbg, cpurst, we, stb, ack, done, err;
    logic [31:0] adr, dat, rdt;
    logic [3:0]  sel;

    always #5 clk = ~clk;

    subservient_loader #(.memsize(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_data(data), .i_valid(valid), .i_last(last),
        .o_ready(ready), .o_debug_mode(dbg), .o_cpu_rst(cpurst),
        .o_wb_dbg_adr(adr), .o_wb_dbg_dat(dat), .o_wb_dbg_sel(sel), .o_wb_dbg_we(we), .o_wb_dbg_stb(stb),
        .i_wb_dbg_rdt(rdt), .i_wb_dbg_ack(ack), .o_done(done), .o_err(err)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_dly = 1;
    bit          corrupt = 1'b0;
    logic [31:0] mem[4];
    int          wcnt = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          dbg_fall = 0;
    logic        rst_at_edge = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Wishbone slave: ack after ack_dly cycles of stb; memory echoes writes on read.
    always @(posedge clk) begin
        #1;
        if (stb && !ack) begin
            wcnt++;
            if (wcnt > ack_dly) begin
                ack  = 1'b1;
                wcnt = 0;
                if (we) mem[adr[3:2]] = dat;
                else    rdt = corrupt ? 32'hDEADBEEF : mem[adr[3:2]];
            end
        end else begin
            ack  = 1'b0;
            wcnt = 0;
        end
    end

    always @(posedge clk) rst_at_edge <= rst;

    logic        stb_p = 1'b0, ack_p = 1'b0, done_p = 1'b0, dbg_p = 1'b0, cpurst_p = 1'b0, we_p = 1'b0;
    logic [31:0] adr_p, dat_p;
    logic [3:0]  sel_p;

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (stb && ack && we) begin
            if (exp_q.size() == 0) begin
                tmo("unexpected_write");
            end else begin
                e = exp_q.pop_front();
                chk("wr_adr", adr, e.adr);
                chk("wr_dat", dat, e.dat);
                chk("wr_sel", sel, e.sel);
            end
        end
        if (stb_p && !ack_p && stb) begin
            chk("hold_bus", {we, sel, adr, dat}, {we_p, sel_p, adr_p, dat_p});
            chk("hold_ready", ready, 1'b0);
        end
        if (done_p) chk("done_width", done, 1'b0);
        if (done && !done_p) done_cnt++;
        if (dbg_p && !dbg && !rst_at_edge) begin
            chk("release_cpurst", cpurst, 1'b1);
            dbg_fall = cyc;
        end
        if (cpurst_p && !cpurst && !rst_at_edge) chk("release_order", cyc - dbg_fall, 1);
        stb_p = stb; ack_p = ack; done_p = done; dbg_p = dbg; cpurst_p = cpurst; we_p = we;
        adr_p = adr; dat_p = dat; sel_p = sel;
    end

    task automatic send(input logic [7:0] bq[$]);
        for (int i = 0; i < bq.size(); i++) begin
            int t = 0;
            @(negedge clk);
            valid = 1'b1;
            data  = bq[i];
            last  = (i == bq.size() - 1);
            while (!ready && t < 60) begin
                @(negedge clk);
                t++;
            end
            if (t >= 60) begin
                tmo("send_ready");
                break;
            end
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < n) tmo("wait_done");
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t e;
        e.adr = a; e.dat = d; e.sel = s;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; data = 8'h00;
        ack = 1'b0; rdt = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ctrl", {ready, dbg, cpurst, stb, we, done, err}, 7'd0);
        chk("rst_adr", adr, 32'h0);
        chk("rst_dat", dat, 32'h0);
        chk("rst_sel", sel, 4'h0);

        // Two full words; i_start held high through the load must be ignored.
        push(32'h0, 32'h44332211, 4'hF);
        push(32'h4, 32'h88776655, 4'hF);
        @(negedge clk);
        start = 1'b1;
        send('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
        start = 1'b0;
        wait_done(1);
        chk("s1_err", err, 1'b0);
        chk("s1_idle", {ready, dbg, cpurst}, 3'b000);

        // Partial word.
        push(32'h0, 32'h00CCBBAA, 4'h7);
        pulse_start();
        send('{8'hAA, 8'hBB, 8'hCC});
        wait_done(2);
        chk("s2_err", err, 1'b0);

        // Slow slave with a partial trailing word.
        ack_dly = 5;
        push(32'h0, 32'hA3A2A1A0, 4'hF);
        push(32'h4, 32'h0000A5A4, 4'h3);
        pulse_start();
        send('{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5});
        wait_done(3);
        ack_dly = 1;
        chk("s3_err", err, 1'b0);

        // 20 bytes into a 4-word memory: fifth word wraps to 0.
        push(32'h0, 32'h04030201, 4'hF);
        push(32'h4, 32'h08070605, 4'hF);
        push(32'h8, 32'h0C0B0A09, 4'hF);
        push(32'hC, 32'h100F0E0D, 4'hF);
        push(32'h0, 32'h14131211, 4'hF);
        pulse_start();
        send('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
               8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
        wait_done(4);
        chk("s4_wrap_err", err, 1'b1);

        // Reset in the middle of a write, then a fresh load from address 0.
        ack_dly = 20;
        pulse_start();
        send('{8'h5A, 8'h5B, 8'h5C, 8'h5D});
        chk("s5_in_write", stb, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s5_after_rst", {stb, dbg, cpurst, ready, err}, 5'd0);
        repeat (25) @(negedge clk);
        chk("s5_no_write", stb, 1'b0);
        ack_dly = 1;
        push(32'h0, 32'h00CCBBAA, 4'h7);
        pulse_start();
        send('{8'hAA, 8'hBB, 8'hCC});
        wait_done(5);
        chk("s5_err", err, 1'b0);

`ifdef SUBSERVIENT_LOADER_READBACK_EN
        corrupt = 1'b1;
        push(32'h0, 32'h44332211, 4'hF);
        pulse_start();
        send('{8'h11, 8'h22, 8'h33, 8'h44});
        wait_done(6);
        corrupt = 1'b0;
        chk("s6_rb_err", err, 1'b1);
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
`ifdef SUBSERVIENT_LOADER_READBACK_EN
        chk("done_total", done_cnt, 6);
`else
        chk("done_total", done_cnt, 5);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/subservient_loader.md
SUBSERVIENT_LOADER -- requirements
Module: subservient_loader

Interface
REQ-001 SHALL have parameter memsize, default 512: SRAM size in bytes, a power of two and at least 8.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_start, input, 1 bit: load request, sampled only in IDLE.
REQ-005 SHALL have port i_data, input, 8 bits: program byte stream.
REQ-006 SHALL have port i_valid, input, 1 bit: i_data valid.
REQ-007 SHALL have port i_last, input, 1 bit: current byte is the final byte of the image.
REQ-008 SHALL have port o_ready, output, 1 bit: byte accepted when i_valid and o_ready are both high.
REQ-009 SHALL have port o_debug_mode, output, 1 bit: drives the debug switch select.
REQ-010 SHALL have port o_cpu_rst, output, 1 bit: holds the CPU in reset during a load.
REQ-011 SHALL have ports o_wb_dbg_adr (32 bits), o_wb_dbg_dat (32 bits), o_wb_dbg_sel (4 bits), o_wb_dbg_we (1 bit) and o_wb_dbg_stb (1 bit), all outputs: debug Wishbone master.
REQ-012 SHALL have ports i_wb_dbg_rdt (32 bits) and i_wb_dbg_ack (1 bit), both inputs.
REQ-013 SHALL have port o_done, output, 1 bit: one-cycle pulse when a load completes.
REQ-014 SHALL have port o_err, output, 1 bit: sticky error flag.

Function
REQ-015 SHALL implement the states IDLE, COLLECT, WRITE and RELEASE, plus CHECK when readback is enabled (REQ-030).
REQ-016 IDLE: o_ready=0, o_debug_mode=0, o_cpu_rst=0; i_start=1 -> COLLECT, with word address cleared to 0, byte lane cleared to 0 and o_err cleared.
REQ-017 COLLECT: o_ready=1, o_debug_mode=1, o_cpu_rst=1; each accepted byte goes into lane k, bits [8k+7:8k] (little-endian), the sel bit for that lane is set, and k increments.
REQ-018 Acceptance of the lane-3 byte, or of any byte with i_last=1, -> WRITE on the next cycle; the last flag is registered.
REQ-019 WRITE: o_wb_dbg_stb=1 and o_wb_dbg_we=1; o_wb_dbg_adr = {word address, 2'b00}; o_wb_dbg_sel holds only the collected lanes; o_ready=0.
REQ-020 WRITE SHALL hold stb and all bus outputs stable until i_wb_dbg_ack, and SHALL deassert stb in the cycle after the ack.
REQ-021 On ack: the word address increments, wrapping at memsize/4 to 0; lanes and sel clear; state -> RELEASE if the last flag is set, else COLLECT.
REQ-022 A wrap SHALL set o_err and the load SHALL continue.
REQ-023 RELEASE lasts one cycle: o_debug_mode=0, o_cpu_rst=1, then -> IDLE with o_done=1 for exactly that transition cycle.
REQ-024 i_start outside IDLE SHALL be ignored.
REQ-025 i_valid while o_ready=0 SHALL not be consumed.
REQ-026 An unused data lane SHALL be driven as 0.
REQ-027 Only one Wishbone transaction SHALL be outstanding at a time; a write completes in a minimum of 2 cycles (stb cycle, then ack).

Reset
REQ-028 i_rst SHALL force IDLE from any state, including mid-WRITE, with stb dropped in the following cycle and no further writes issued.
REQ-029 Reset values SHALL be: o_ready=0, o_debug_mode=0, o_cpu_rst=0, o_wb_dbg_stb=0, o_wb_dbg_we=0, o_wb_dbg_adr=0, o_wb_dbg_dat=0, o_wb_dbg_sel=0, o_done=0, o_err=0, word address=0, lane=0.

Configuration
REQ-030 With SUBSERVIENT_LOADER_READBACK_EN defined, the ack of each write SHALL go to CHECK instead of advancing.
REQ-031 CHECK SHALL issue a read (stb=1, we=0) to the same address and, on ack, compare i_wb_dbg_rdt against the written data under sel.
REQ-032 A readback mismatch SHALL set o_err, after which the FSM SHALL continue as in REQ-021.
REQ-033 Without SUBSERVIENT_LOADER_READBACK_EN, CHECK SHALL not exist, o_wb_dbg_we SHALL equal o_wb_dbg_stb, and i_wb_dbg_rdt SHALL be unused.

Verification
REQ-034 Scenario: reset, then start, then bytes 11 22 33 44 55 66 77 88 with last on 88, bus slave acking 1 cycle after stb -> writes adr 0x0 dat 0x44332211 sel F, then adr 0x4 dat 0x88776655 sel F; o_done pulses once; o_debug_mode falls one cycle before o_cpu_rst.
REQ-035 Scenario: bytes AA BB CC with last on CC -> single write adr 0x0 dat 0x00CCBBAA sel 0111.
REQ-036 Scenario: memsize=16, 20 bytes -> fifth write at adr 0x0, o_err=1, o_done still pulses.
REQ-037 Scenario: ack delayed 5 cycles with i_valid held high -> o_ready=0 and stb/adr/dat stable throughout; no byte lost.
REQ-038 Scenario: i_rst asserted during WRITE -> next cycle IDLE with stb=0, debug_mode=0, cpu_rst=0; a new start then writes at adr 0x0.
REQ-039 Scenario, READBACK_EN only: slave returns 0xDEADBEEF on readback of 0x44332211 -> o_err=1.
